e_stage_mdu: RTL and testbench

Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline. It consumes the rs/rt operand values and the decoded MD operation leaving the ID/EX pipeline register. It holds the architectural HI/LO registers and models multi-cycle latency with a countdown. It reports busy and a stall request to the hazard unit, which must hold any later MD instruction in D.

---
 rtl/e_stage_mdu_pkg.sv | 23 ++
 rtl/e_stage_mdu_if.sv | 24 ++
 rtl/e_stage_mdu.sv | 130 +++++++++++++
 tb/tb_e_stage_mdu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_stage_mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// MD operation encodings, default latencies and the op-class helper.
package e_stage_mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the ops that open a multi-cycle busy period.
    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_stage_mdu_if.sv
// Execute-stage MD bundle: operands and op from ID/EX, status and HI/LO back out.
interface e_stage_mdu_if;

    logic [3:0]  md_op;
    logic        start;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data;

    modport master (
        output md_op, start, rs_data, rt_data,
        input  busy, stall_req, hi_out, lo_out, mf_data
    );

    modport slave (
        input  md_op, start, rs_data, rt_data,
        output busy, stall_req, hi_out, lo_out, mf_data
    );

endinterface

// File: rtl/e_stage_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes results at the
// start edge into pending registers and commits them when the countdown expires.
module e_stage_mdu
    import e_stage_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    e_stage_mdu_if.slave  md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic             pending_we;

    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic signed [63:0] rs_sx;
    logic signed [63:0] rt_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] div_s;
    logic        [63:0] div_u;

    // Signed divide returning {remainder, quotient}; zero divisor yields 0 so
    // no X leaks into pending (the result is never committed in that case).
    function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                               input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'sd0) begin
            q = 32'sd0;
            r = 32'sd0;
        end else if (n == 32'sh8000_0000 && d == -32'sd1) begin
            q = n;
            r = 32'sd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] n,
                                                 input logic [31:0] d);
        logic [31:0] q;
        logic [31:0] r;
        if (d == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    assign rs_s   = md.rs_data;
    assign rt_s   = md.rt_data;
    assign rs_sx  = 64'(rs_s);
    assign rt_sx  = 64'(rt_s);
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};
    assign div_s  = div_signed(rs_s, rt_s);
    assign div_u  = div_unsigned(md.rs_data, md.rt_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_we <= 1'b0;
        end else if (count != '0) begin
            // Busy: inputs ignored; commit on the 1->0 transition.
            count <= count - 1'b1;
            if (count == CNT_W'(1) && pending_we) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end
        end else if (md.start) begin
            case (md.md_op)
                MD_MULT: begin
                    {pending_hi, pending_lo} <= prod_s;
                    pending_we <= 1'b1;
                    count      <= CNT_W'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    {pending_hi, pending_lo} <= prod_u;
                    pending_we <= 1'b1;
                    count      <= CNT_W'(MULT_CYCLES);
                end
                MD_DIV: begin
                    {pending_hi, pending_lo} <= div_s;
                    pending_we <= (md.rt_data != 32'd0);
                    count      <= CNT_W'(DIV_CYCLES);
                end
                MD_DIVU: begin
                    {pending_hi, pending_lo} <= div_u;
                    pending_we <= (md.rt_data != 32'd0);
                    count      <= CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi <= md.rs_data;
                MD_MTLO: lo <= md.rs_data;
                default: ;
            endcase
        end
    end

    assign md.busy      = (count != '0);
    assign md.stall_req = md.busy | (md.start & is_md_start(md.md_op));
    assign md.hi_out    = hi;
    assign md.lo_out    = lo;

    always_comb begin
        md.mf_data = 32'd0;
        if (md.md_op == MD_MFHI)      md.mf_data = hi;
        else if (md.md_op == MD_MFLO) md.mf_data = lo;
    end

endmodule

// File: tb/tb_e_stage_mdu.sv
// Self-checking bench for e_stage_mdu: directed scenarios plus randomized
// traffic compared against an arithmetic model of HI/LO.
module tb_e_stage_mdu;
    import e_stage_mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_stage_mdu_if bus();

    e_stage_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.md_op   = MD_NONE;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
    endtask

    // Reference: HI/LO after an op, computed from magnitudes and signs.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint            p;
        longint unsigned   pu;
        logic [31:0]       ua, ub, q, r;
        case (op)
            MD_MULT: begin
                p = longint'(int'(a)) * longint'(int'(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MD_MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            MD_DIV: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        ua = a[31] ? -a : a;
                        ub = b[31] ? -b : b;
                        q  = ua / ub;
                        r  = ua % ub;
                        m_lo = (a[31] ^ b[31]) ? -q : q;
                        m_hi = a[31] ? -r : r;
                    end
                end
            end
            MD_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle, check stall_req, busy length and final HI/LO.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int   n;
        int   exp_n;
        logic exp_stall;
        exp_stall = (op >= 4'd1 && op <= 4'd4);
        exp_n = (op == MD_MULT || op == MD_MULTU) ? 5 :
                (op == MD_DIV  || op == MD_DIVU)  ? 10 : 0;
        bus.start = 1'b1; bus.md_op = op; bus.rs_data = a; bus.rt_data = b;
        #1;
        n_checks++;
        if (bus.stall_req !== exp_stall) begin
            n_fail++;
            $display("FAIL stall_req_start op=%0d got=%b exp=%b", op, bus.stall_req, exp_stall);
        end
        tick();
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != exp_n) begin
            n_fail++;
            $display("FAIL busy_cycles op=%0d got=%0d exp=%0d", op, n, exp_n);
        end
        model_op(op, a, b);
        n_checks++;
        if (bus.hi_out !== m_hi || bus.lo_out !== m_lo) begin
            n_fail++;
            $display("FAIL hilo op=%0d a=%h b=%h got=%h/%h exp=%h/%h",
                     op, a, b, bus.hi_out, bus.lo_out, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.hi_out !== 32'd0 ||
            bus.lo_out !== 32'd0 || bus.mf_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h mf=%h exp all zero",
                     bus.busy, bus.stall_req, bus.hi_out, bus.lo_out, bus.mf_data);
        end
    endtask

    task automatic test_mult();
        issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
        n_checks++;
        if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_const got=%h/%h exp=ffffffff/ffffffeb", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_div();
        issue(MD_DIVU, 32'd100, 32'd7);
        n_checks++;
        if (bus.hi_out !== 32'd2 || bus.lo_out !== 32'd14) begin
            n_fail++;
            $display("FAIL divu_const got=%h/%h exp=2/e", bus.hi_out, bus.lo_out);
        end
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg got=%h/%h exp=ffffffff/fffffffd", bus.hi_out, bus.lo_out);
        end
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_ovf got=%h/%h exp=0/80000000", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_mt_during_busy();
        int n;
        issue(MD_MTHI, 32'h1234, 32'd0);
        n_checks++;
        if (bus.hi_out !== 32'h1234 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi got hi=%h busy=%b exp hi=1234 busy=0", bus.hi_out, bus.busy);
        end
        bus.start = 1'b1; bus.md_op = MD_MULTU; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
        tick();
        idle_inputs();
        tick();
        bus.start = 1'b1; bus.md_op = MD_MTLO; bus.rs_data = 32'hAAAA;
        tick();
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        m_hi = 32'd0;
        m_lo = 32'd12;
        n_checks++;
        if (bus.hi_out !== m_hi || bus.lo_out !== m_lo || n != 3) begin
            n_fail++;
            $display("FAIL mtlo_ignored got=%h/%h tail=%0d exp=0/c tail=3", bus.hi_out, bus.lo_out, n);
        end
    endtask

    task automatic test_div_zero();
        int n;
        issue(MD_MTHI, 32'h11, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        bus.start = 1'b1; bus.md_op = MD_DIV; bus.rs_data = 32'd55; bus.rt_data = 32'd0;
        tick();
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            if (n == 3) begin
                bus.start = 1'b1; bus.md_op = MD_MFLO;
                #1;
                n_checks++;
                if (bus.mf_data !== 32'h22 || bus.stall_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mflo_busy got mf=%h stall=%b exp mf=22 stall=1", bus.mf_data, bus.stall_req);
                end
                idle_inputs();
            end
            n++;
            tick();
        end
        n_checks++;
        if (n != 10 || bus.hi_out !== 32'h11 || bus.lo_out !== 32'h22) begin
            n_fail++;
            $display("FAIL div_zero got cycles=%0d hi=%h lo=%h exp 10/11/22", n, bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_reset_midway();
        bus.start = 1'b1; bus.md_op = MD_DIV; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midway busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi_out, bus.lo_out);
        end
        repeat (12) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_fail++;
            $display("FAIL no_late_commit busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 8));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
            if (op == MD_DIV && $urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (op == MD_MFHI || op == MD_MFLO) begin
                bus.start = 1'b1; bus.md_op = op;
                #1;
                n_checks++;
                if (bus.mf_data !== ((op == MD_MFHI) ? m_hi : m_lo) || bus.stall_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mf_read op=%0d got=%h exp=%h stall=%b", op, bus.mf_data,
                             (op == MD_MFHI) ? m_hi : m_lo, bus.stall_req);
                end
                tick();
                idle_inputs();
                n_checks++;
                if (bus.hi_out !== m_hi || bus.lo_out !== m_lo || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mf_no_effect got=%h/%h busy=%b exp=%h/%h", bus.hi_out, bus.lo_out,
                             bus.busy, m_hi, m_lo);
                end
            end else begin
                issue(op, a, b);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_mt_during_busy();
        test_div_zero();
        test_reset_midway();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
